// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI line-bridge port between ICache refills and DCache refills/writebacks (CACHE_ARB_RR_EN selects round-robin)
module cache_axi_arbiter #(
  parameter int LINE_OFS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_rd_req,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic [127:0] i_ret_data,
  input  logic         d_rd_req,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic [127:0] d_ret_data,
  input  logic         d_wr_req,
  input  logic [31:0]  d_wr_addr,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         d_wr_valid,
  output logic         m_rd_req,
  output logic [31:0]  m_rd_addr,
  input  logic         m_rd_rdy,
  input  logic         m_ret_valid,
  input  logic [127:0] m_ret_data,
  output logic         m_wr_req,
  output logic [31:0]  m_wr_addr,
  output logic [127:0] m_wr_data,
  input  logic         m_wr_rdy,
  input  logic         m_wr_valid
);
  localparam int LW = 32 - LINE_OFS;
  typedef enum logic [1:0] {R_IDLE, R_WAIT_I, R_WAIT_D} r_state_t;
  typedef enum logic {W_IDLE, W_WAIT} w_state_t;
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [LW-1:0] wr_line;
  logic wr_acc, i_elig, d_elig, pick_d, grant_i, grant_d;
  // a refill must not overtake a writeback to the same line, whether pending or being accepted now
  assign wr_acc = (w_state == W_IDLE) && d_wr_req && m_wr_rdy;
  assign i_elig = i_rd_req &&
    !((w_state == W_WAIT) && i_rd_addr[31:LINE_OFS] == wr_line) &&
    !(wr_acc && i_rd_addr[31:LINE_OFS] == d_wr_addr[31:LINE_OFS]);
  assign d_elig = d_rd_req &&
    !((w_state == W_WAIT) && d_rd_addr[31:LINE_OFS] == wr_line) &&
    !(wr_acc && d_rd_addr[31:LINE_OFS] == d_wr_addr[31:LINE_OFS]);
`ifdef CACHE_ARB_RR_EN
  logic last_grant_d;
  assign pick_d = !i_elig || !last_grant_d;
  // remember who won the last accepted read for round-robin fairness
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) last_grant_d <= 1'b0;
    else if (i_rd_rdy || d_rd_rdy) last_grant_d <= d_rd_rdy;
`else
  assign pick_d = 1'b1;
`endif
  assign grant_d = (r_state == R_IDLE) && d_elig && pick_d;
  assign grant_i = (r_state == R_IDLE) && i_elig && !grant_d;
  // read and write state registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= R_IDLE;
    else r_state <= r_next;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      w_state <= W_IDLE;
      wr_line <= '0;
    end else begin
      w_state <= w_next;
      if (wr_acc) wr_line <= d_wr_addr[31:LINE_OFS];
    end
  // read path: forward the winner, route the return to the owner only
  always_comb begin
    m_rd_req    = grant_i || grant_d;
    m_rd_addr   = grant_d ? d_rd_addr : grant_i ? i_rd_addr : '0;
    i_rd_rdy    = grant_i && m_rd_rdy;
    d_rd_rdy    = grant_d && m_rd_rdy;
    i_ret_valid = (r_state == R_WAIT_I) && m_ret_valid;
    d_ret_valid = (r_state == R_WAIT_D) && m_ret_valid;
    i_ret_data  = i_ret_valid ? m_ret_data : '0;
    d_ret_data  = d_ret_valid ? m_ret_data : '0;
    r_next      = i_rd_rdy ? R_WAIT_I : d_rd_rdy ? R_WAIT_D :
                  (i_ret_valid || d_ret_valid) ? R_IDLE : r_state;
  end
  // write path: pass the writeback through while idle, then wait for completion
  always_comb begin
    m_wr_req   = (w_state == W_IDLE) && d_wr_req;
    m_wr_addr  = (w_state == W_IDLE) ? d_wr_addr : '0;
    m_wr_data  = (w_state == W_IDLE) ? d_wr_data : '0;
    d_wr_rdy   = wr_acc;
    d_wr_valid = (w_state == W_WAIT) && m_wr_valid;
    w_next     = wr_acc ? W_WAIT : d_wr_valid ? W_IDLE : w_state;
  end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed checks of arbitration, hazard blocking, routing and reset
module tb_cache_axi_arbiter;
  logic clk = 0, resetn = 0;
  logic i_rd_req = 0, d_rd_req = 0, d_wr_req = 0;
  logic [31:0] i_rd_addr = 0, d_rd_addr = 0, d_wr_addr = 0;
  logic [127:0] d_wr_data = 0, m_ret_data = 0;
  logic m_rd_rdy = 0, m_ret_valid = 0, m_wr_rdy = 0, m_wr_valid = 0;
  logic i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid, d_wr_rdy, d_wr_valid, m_rd_req, m_wr_req;
  logic [127:0] i_ret_data, d_ret_data, m_wr_data;
  logic [31:0] m_rd_addr, m_wr_addr;
  logic [455:0] outs;
  int n_chk = 0, n_fail = 0;
`ifdef CACHE_ARB_RR_EN
  localparam logic [2:0] EXP_D = 3'b101;
`else
  localparam logic [2:0] EXP_D = 3'b111;
`endif
  always #5 clk = ~clk;
  assign outs = {i_rd_rdy, i_ret_valid, i_ret_data, d_rd_rdy, d_ret_valid, d_ret_data,
                 d_wr_rdy, d_wr_valid, m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data};
  cache_axi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .d_wr_valid(d_wr_valid),
    .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_data(m_ret_data),
    .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy),
    .m_wr_valid(m_wr_valid)
  );
  task automatic test_reset();
    resetn = 0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    @(negedge clk);
    resetn = 1;
    #1;
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs got=%h want=0", outs);
    end
  endtask
  task automatic test_icache_alone();
    @(negedge clk);
    i_rd_req = 1; i_rd_addr = 32'h1FC0_0040; m_rd_rdy = 1;
    #1;
    n_chk++;
    if ({m_rd_req, m_rd_addr, i_rd_rdy, d_rd_rdy} !== {1'b1, 32'h1FC0_0040, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL icache_req got=%b %h %b %b want=1 1fc00040 1 0", m_rd_req, m_rd_addr, i_rd_rdy, d_rd_rdy);
    end
    @(negedge clk);
    i_rd_req = 0; i_rd_addr = 0;
    #1;
    n_chk++;
    if ({m_rd_req, i_rd_rdy, i_ret_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL icache_wait got=%b%b%b want=000", m_rd_req, i_rd_rdy, i_ret_valid);
    end
    @(negedge clk);
    m_ret_valid = 1; m_ret_data = {16{8'hA5}};
    #1;
    n_chk++;
    if ({i_ret_valid, i_ret_data} !== {1'b1, {16{8'hA5}}}) begin
      n_fail++;
      $display("FAIL icache_ret got=%b %h want=1 a5..a5", i_ret_valid, i_ret_data);
    end
    n_chk++;
    if ({d_ret_valid, d_ret_data} !== '0) begin
      n_fail++;
      $display("FAIL icache_ret_dside got=%b %h want=0", d_ret_valid, d_ret_data);
    end
    @(negedge clk);
    m_ret_valid = 0; m_ret_data = 0;
  endtask
  task automatic test_arbitration();
    logic [2:0] exp_d;
    logic e;
    exp_d = EXP_D;
    for (int k = 0; k < 3; k++) begin
      e = exp_d[k];
      @(negedge clk);
      m_ret_valid = 0;
      i_rd_req = 1; i_rd_addr = 32'h100; d_rd_req = 1; d_rd_addr = 32'h200;
      #1;
      n_chk++;
      if ({i_rd_rdy, d_rd_rdy, m_rd_addr} !== {!e, e, e ? 32'h200 : 32'h100}) begin
        n_fail++;
        $display("FAIL arb_grant%0d got=%b%b %h want=%b%b", k, i_rd_rdy, d_rd_rdy, m_rd_addr, !e, e);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if ({i_rd_rdy, d_rd_rdy, m_rd_req} !== 3'b000) begin
        n_fail++;
        $display("FAIL arb_wait%0d got=%b%b%b want=000", k, i_rd_rdy, d_rd_rdy, m_rd_req);
      end
      @(negedge clk);
      m_ret_valid = 1; m_ret_data = 128'(k + 1);
      #1;
      n_chk++;
      if ({i_ret_valid, d_ret_valid, i_ret_data | d_ret_data} !== {!e, e, 128'(k + 1)}) begin
        n_fail++;
        $display("FAIL arb_ret%0d got=%b%b want=%b%b", k, i_ret_valid, d_ret_valid, !e, e);
      end
    end
    @(negedge clk);
    m_ret_valid = 0; m_ret_data = 0;
    i_rd_req = 0; i_rd_addr = 0; d_rd_req = 0; d_rd_addr = 0;
  endtask
  task automatic test_hazard();
    @(negedge clk);
    d_wr_req = 1; d_wr_addr = 32'h8000_1230; d_wr_data = {4{32'hDEAD_BEEF}}; m_wr_rdy = 1;
    d_rd_req = 1; d_rd_addr = 32'h8000_123C;
    #1;
    n_chk++;
    if ({d_wr_rdy, m_wr_req, m_wr_addr, d_rd_rdy, m_rd_req} !== {1'b1, 1'b1, 32'h8000_1230, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hazard_accept got=%b%b %h %b%b want=11 80001230 00", d_wr_rdy, m_wr_req, m_wr_addr, d_rd_rdy, m_rd_req);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d_wr_req = 0; d_wr_addr = 0; d_wr_data = 0;
      i_rd_req = (k == 0); i_rd_addr = (k == 0) ? 32'h400 : 32'h0;
      m_ret_valid = (k == 1);
      #1;
      n_chk++;
      if ({d_rd_rdy, d_wr_rdy, d_wr_valid, m_wr_req} !== 4'b0000) begin
        n_fail++;
        $display("FAIL hazard_block%0d got=%b%b%b%b want=0000", k, d_rd_rdy, d_wr_rdy, d_wr_valid, m_wr_req);
      end
      if (k == 0) begin
        n_chk++;
        if ({i_rd_rdy, m_rd_addr} !== {1'b1, 32'h400}) begin
          n_fail++;
          $display("FAIL hazard_igrant got=%b %h want=1 00000400", i_rd_rdy, m_rd_addr);
        end
      end
      if (k == 1) begin
        n_chk++;
        if ({i_ret_valid, d_ret_valid} !== 2'b10) begin
          n_fail++;
          $display("FAIL hazard_iret got=%b%b want=10", i_ret_valid, d_ret_valid);
        end
      end
    end
    @(negedge clk);
    m_wr_valid = 1;
    #1;
    n_chk++;
    if ({d_wr_valid, d_rd_rdy} !== 2'b10) begin
      n_fail++;
      $display("FAIL hazard_wrdone got=%b%b want=10", d_wr_valid, d_rd_rdy);
    end
    @(negedge clk);
    m_wr_valid = 0;
    #1;
    n_chk++;
    if ({d_rd_rdy, m_rd_addr} !== {1'b1, 32'h8000_123C}) begin
      n_fail++;
      $display("FAIL hazard_release got=%b %h want=1 8000123c", d_rd_rdy, m_rd_addr);
    end
    @(negedge clk);
    d_rd_req = 0; d_rd_addr = 0; m_ret_valid = 1; m_ret_data = 128'h5;
    #1;
    n_chk++;
    if ({d_ret_valid, d_ret_data, i_ret_valid} !== {1'b1, 128'h5, 1'b0}) begin
      n_fail++;
      $display("FAIL hazard_dret got=%b %h %b want=1 5 0", d_ret_valid, d_ret_data, i_ret_valid);
    end
    @(negedge clk);
    m_ret_valid = 0; m_ret_data = 0;
  endtask
  task automatic test_overlap();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d_wr_req = 1; d_wr_addr = 32'h10; d_wr_data = 128'h77;
      i_rd_req = (k == 0); d_rd_req = (k == 1);
      i_rd_addr = (k == 0) ? 32'h400 : 32'h0; d_rd_addr = (k == 1) ? 32'h400 : 32'h0;
      #1;
      n_chk++;
      if ({d_wr_rdy, i_rd_rdy, d_rd_rdy, m_wr_data} !== {1'b1, k == 0, k == 1, 128'h77}) begin
        n_fail++;
        $display("FAIL overlap_accept%0d got=%b%b%b want=1%b%b", k, d_wr_rdy, i_rd_rdy, d_rd_rdy, k == 0, k == 1);
      end
      @(negedge clk);
      d_wr_req = 0; d_wr_addr = 0; d_wr_data = 0;
      i_rd_req = 0; d_rd_req = 0; i_rd_addr = 0; d_rd_addr = 0;
      m_wr_valid = (k == 0); m_ret_valid = (k == 1); m_ret_data = 128'h99;
      #1;
      n_chk++;
      if ({d_wr_valid, i_ret_valid, d_ret_valid} !== {k == 0, 1'b0, k == 1}) begin
        n_fail++;
        $display("FAIL overlap_first%0d got=%b%b%b want=%b0%b", k, d_wr_valid, i_ret_valid, d_ret_valid, k == 0, k == 1);
      end
      @(negedge clk);
      m_wr_valid = (k == 1); m_ret_valid = (k == 0);
      #1;
      n_chk++;
      if ({d_wr_valid, i_ret_valid, d_ret_valid, i_ret_data | d_ret_data} !== {k == 1, k == 0, 1'b0, (k == 0) ? 128'h99 : 128'h0}) begin
        n_fail++;
        $display("FAIL overlap_second%0d got=%b%b%b want=%b%b0", k, d_wr_valid, i_ret_valid, d_ret_valid, k == 1, k == 0);
      end
      @(negedge clk);
      m_wr_valid = 0; m_ret_valid = 0; m_ret_data = 0;
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    d_rd_req = 1; d_rd_addr = 32'h200;
    #1;
    n_chk++;
    if (d_rd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_accept got=%b want=1", d_rd_rdy);
    end
    @(negedge clk);
    d_rd_req = 0; d_rd_addr = 0; resetn = 0;
    #1;
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_during got=%h want=0", outs);
    end
    @(negedge clk);
    resetn = 1; m_ret_valid = 1; m_ret_data = {8{16'hFFFF}};
    #1;
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_stray got=%h want=0", outs);
    end
    @(negedge clk);
    m_ret_valid = 0; m_ret_data = 0;
  endtask
  initial begin
    test_reset();
    test_icache_alone();
    test_arbitration();
    test_hazard();
    test_overlap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
